// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_access_ctrl
// Desc   : MEM-stage initiator; splits word loads/stores into byte beats for data_Mem.
// Rev    : 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int N      = 32,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic         req_byte,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic         resp_err,
    output logic [N-1:0] resp_rdata,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         mem_re,
    output logic         mem_we,
    output logic         mem_isbyte
);
    localparam int BEATS = N / DATA_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat, beat_nxt;
    logic          op_write, op_write_nxt;
    logic          op_byte, op_byte_nxt;
    logic [N-1:0]  op_addr, op_addr_nxt;
    logic [N-1:0]  op_wdata, op_wdata_nxt;
    logic [N-1:0]  asm_word, asm_word_nxt;
    logic          req_ready_nxt;
    logic          resp_valid_nxt;
    logic          resp_err_nxt;
    logic [N-1:0]  resp_rdata_nxt;
    logic [N-1:0]  mem_addr_nxt;
    logic [N-1:0]  mem_wdata_nxt;
    logic          mem_re_nxt;
    logic          mem_we_nxt;

    // Only the low byte lane of the memory read bus is meaningful.
    logic unused_rdata_hi;
    assign unused_rdata_hi = |mem_rdata[N-1:DATA_W];

    assign mem_isbyte = op_byte;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= '0;
            op_write   <= 1'b0;
            op_byte    <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            asm_word   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            op_write   <= op_write_nxt;
            op_byte    <= op_byte_nxt;
            op_addr    <= op_addr_nxt;
            op_wdata   <= op_wdata_nxt;
            asm_word   <= asm_word_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_re     <= mem_re_nxt;
            mem_we     <= mem_we_nxt;
        end
    end

    // Outputs are computed for the state being entered, so they are registered with it.
    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        op_write_nxt   = op_write;
        op_byte_nxt    = op_byte;
        op_addr_nxt    = op_addr;
        op_wdata_nxt   = op_wdata;
        asm_word_nxt   = asm_word;
        req_ready_nxt  = req_ready;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = resp_rdata;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        mem_re_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_write_nxt  = req_write;
                    op_byte_nxt   = req_byte;
                    op_addr_nxt   = req_addr;
                    op_wdata_nxt  = req_wdata;
                    req_ready_nxt = 1'b0;
                    beat_nxt      = '0;
                    if (!req_byte && (req_addr[BW-1:0] != '0)) begin
                        state_nxt      = DONE;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = ISSUE;
                        mem_addr_nxt  = req_addr;
                        mem_re_nxt    = !req_write;
                        mem_we_nxt    = req_write;
                        mem_wdata_nxt = '0;
                        mem_wdata_nxt[DATA_W-1:0] = req_wdata[DATA_W-1:0];
                    end
                end
            end
            ISSUE: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!op_write) begin
                    asm_word_nxt[int'(beat)*DATA_W +: DATA_W] = mem_rdata[DATA_W-1:0];
                end
                if (op_byte || (beat == LAST_BEAT)) begin
                    state_nxt      = DONE;
                    resp_valid_nxt = 1'b1;
                    if (!op_write) begin
                        resp_rdata_nxt = op_byte ? N'(mem_rdata[DATA_W-1:0]) : asm_word_nxt;
                    end
                end else begin
                    beat_nxt      = beat + 1'b1;
                    state_nxt     = ISSUE;
                    mem_addr_nxt  = op_addr + N'(beat_nxt);
                    mem_re_nxt    = !op_write;
                    mem_we_nxt    = op_write;
                    mem_wdata_nxt = '0;
                    mem_wdata_nxt[DATA_W-1:0] = op_wdata[int'(beat_nxt)*DATA_W +: DATA_W];
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_ctrl
// Desc   : Self-checking bench for mem_access_ctrl against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_re, mem_we, mem_isbyte;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] ram [256];
    assign mem_rdata = {24'hA5A5A5, ram[mem_addr[7:0]]};

    always #5 clk = ~clk;

    mem_access_ctrl #(.N(32), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_isbyte(mem_isbyte)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: one request in flight, timeline derived from offset since accept.
    bit          chk_en = 1'b0;
    bit          active = 1'b0;
    bit          was_idle;
    int          offs = 0, dlen = 0, nb = 1;
    bit          t_write, t_byte, t_err;
    logic [31:0] t_addr = '0, t_wdata = '0, t_load = '0, exp_rdata = '0, a_b;
    int          cyc = 0, acc_cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            was_idle = !active;
            if (rst !== 1'b1) begin
                active    = 1'b0;
                exp_rdata = '0;
            end else begin
                if (active) begin
                    if (offs == dlen) begin
                        active = 1'b0;
                    end else begin
                        offs++;
                        if (offs == dlen && !t_err && !t_write) exp_rdata = t_load;
                    end
                end
                if (was_idle && req_valid) begin
                    t_write = req_write;
                    t_byte  = req_byte;
                    t_addr  = req_addr;
                    t_wdata = req_wdata;
                    t_err   = !req_byte && (req_addr[1:0] != 2'b00);
                    nb      = req_byte ? 1 : 4;
                    dlen    = t_err ? 1 : 2 * nb + 1;
                    t_load  = '0;
                    for (int b = 0; b < nb; b++) begin
                        a_b = req_addr + 32'(b);
                        t_load[8*b +: 8] = ram[a_b[7:0]];
                    end
                    active  = 1'b1;
                    offs    = 1;
                    acc_cyc = cyc;
                end
            end
            cyc++;
        end
    end

    // Per-cycle compare of all outputs against the model.
    initial begin
        bit          en, settle;
        int          b;
        logic [31:0] sh;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                en     = active && !t_err && (offs % 2 == 1) && (offs <= 2 * nb - 1);
                settle = active && !t_err && (offs % 2 == 0) && (offs <= 2 * nb);
                chk("req_ready", 32'(req_ready), 32'(!active));
                chk("mem_re", 32'(mem_re), 32'(en && !t_write));
                chk("mem_we", 32'(mem_we), 32'(en && t_write));
                if (en) begin
                    b  = (offs - 1) / 2;
                    sh = t_wdata >> (8 * b);
                    chk("mem_addr", mem_addr, t_addr + 32'(b));
                    chk("mem_isbyte", 32'(mem_isbyte), 32'(t_byte));
                    if (t_write) chk("mem_wdata", mem_wdata, {24'h0, sh[7:0]});
                end
                if (settle) chk("mem_addr_hold", mem_addr, t_addr + 32'(offs / 2 - 1));
                chk("resp_valid", 32'(resp_valid), 32'(active && offs == dlen));
                if (active && offs == dlen) chk("resp_err", 32'(resp_err), 32'(t_err));
                chk("resp_rdata", resp_rdata, exp_rdata);
            end
        end
    end

    // Emulated data_Mem plus observation logs for the directed scenarios.
    logic [31:0] wlog_addr[$], rlog_addr[$];
    logic [7:0]  wlog_data[$];
    int          rlog_cyc[$], resp_cycs[$];
    int          resp_cnt = 0, resp_cyc = 0;
    logic        resp_err_seen = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                ram[mem_addr[7:0]] = mem_wdata[7:0];
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata[7:0]);
            end
            if (mem_re === 1'b1) begin
                rlog_addr.push_back(mem_addr);
                rlog_cyc.push_back(cyc);
            end
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                resp_cyc = cyc;
                resp_cycs.push_back(cyc);
                resp_err_seen = resp_err;
            end
        end
    end

    task automatic clr_logs();
        wlog_addr.delete(); wlog_data.delete();
        rlog_addr.delete(); rlog_cyc.delete(); resp_cycs.delete();
        resp_cnt = 0;
    endtask

    task automatic start_req(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (req_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", 32'(resp_valid), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp2 [4];
        int t0, n;
        exp2[0] = 8'hEF; exp2[1] = 8'hBE; exp2[2] = 8'hAD; exp2[3] = 8'hDE;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        // Word load
        ram[8'h64] = 8'h11; ram[8'h65] = 8'h22; ram[8'h66] = 8'h33; ram[8'h67] = 8'h44;
        clr_logs();
        start_req(1'b0, 1'b0, 32'h64, 32'h0);
        wait_resp();
        chk("t1_latency", 32'(resp_cyc - acc_cyc), 32'd9);
        chk("t1_rdata", resp_rdata, 32'h44332211);
        chk("t1_err", 32'(resp_err_seen), 32'd0);
        chk("t1_re_count", 32'(rlog_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < rlog_addr.size(); i++) begin
            chk("t1_re_addr", rlog_addr[i], 32'h64 + 32'(i));
            chk("t1_re_cycle", 32'(rlog_cyc[i] - acc_cyc), 32'(2 * i + 1));
        end

        // Word store
        clr_logs();
        start_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        wait_resp();
        chk("t2_latency", 32'(resp_cyc - acc_cyc), 32'd9);
        chk("t2_err", 32'(resp_err_seen), 32'd0);
        chk("t2_we_count", 32'(wlog_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
            chk("t2_we_addr", wlog_addr[i], 32'h10 + 32'(i));
            chk("t2_we_data", 32'(wlog_data[i]), 32'(exp2[i]));
        end

        // Byte load
        ram[8'h65] = 8'h9C;
        clr_logs();
        start_req(1'b0, 1'b1, 32'h65, 32'h0);
        wait_resp();
        chk("t3_latency", 32'(resp_cyc - acc_cyc), 32'd3);
        chk("t3_rdata", resp_rdata, 32'h0000009C);
        chk("t3_re_count", 32'(rlog_addr.size()), 32'd1);

        // Misaligned word load
        clr_logs();
        start_req(1'b0, 1'b0, 32'h66, 32'h0);
        wait_resp();
        chk("t4_latency", 32'(resp_cyc - acc_cyc), 32'd1);
        chk("t4_err", 32'(resp_err_seen), 32'd1);
        chk("t4_rdata_held", resp_rdata, 32'h0000009C);
        chk("t4_mem_access", 32'(rlog_addr.size() + wlog_addr.size()), 32'd0);

        // Reset during a word store, then a byte store
        clr_logs();
        start_req(1'b1, 1'b0, 32'h20, 32'h01020304);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t5_we_after_rst", 32'(mem_we), 32'd0);
        chk("t5_ready_after_rst", 32'(req_ready), 32'd1);
        chk("t5_resp_after_rst", 32'(resp_valid), 32'd0);
        repeat (6) @(negedge clk);
        chk("t5_no_resp", 32'(resp_cnt), 32'd0);
        chk("t5_partial_we", 32'(wlog_addr.size()), 32'd2);
        ram[8'h30] = 8'h00;
        clr_logs();
        start_req(1'b1, 1'b1, 32'h30, 32'h1234565A);
        wait_resp();
        chk("t5_byte_latency", 32'(resp_cyc - acc_cyc), 32'd3);
        chk("t5_byte_err", 32'(resp_err_seen), 32'd0);
        chk("t5_byte_mem", 32'(ram[8'h30]), 32'h5A);
        chk("t5_byte_we_count", 32'(wlog_addr.size()), 32'd1);

        // Back-to-back byte loads with req_valid held
        clr_logs();
        t0 = cyc;
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b1; req_addr = 32'h40; req_wdata = '0;
        n = 0;
        while (resp_cnt < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_resp_count", 32'(resp_cycs.size()), 32'd2);
        if (resp_cycs.size() >= 2) begin
            chk("t6_first_resp", 32'(resp_cycs[0] - t0), 32'd3);
            chk("t6_second_resp", 32'(resp_cycs[1] - t0), 32'd7);
        end

        // Randomized traffic, including stray resets and requests held during busy cycles
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 79) != 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom);
            req_byte  = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (!req_byte && $urandom_range(0, 3) != 0) req_addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) req_addr[31:8] = 24'hFFFFFF;
            @(negedge clk);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
